// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage issuing one req/ack bus access per load/store,
// stalling execute until the bus answers, then returning extended load data.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic [31:0] mem_raddr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  byte_sel_i,
  input  logic        un_sign_i,
  input  logic [4:0]  rd_waddr_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [4:0]  load_waddr_o,
  output logic [31:0] load_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, lwdata_q, lwdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    bs_q, bs_d;
  logic [4:0]    rd_q, rd_d, lwaddr_q, lwaddr_d;
  logic          we_q, we_d, uns_q, uns_d, lv_q, lv_d, mis_q, mis_d, berr_q, berr_d;
  logic [31:0]   addr, fmt_wdata, ext;
  logic [3:0]    fmt_wstrb;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic          req, mis, idle, busy, go, ack, tmo;

  always_comb begin
    addr      = mem_we_i ? mem_waddr_i : mem_raddr_i;
    req       = (mem_we_i | mem_re_i) & |byte_sel_i;
    mis       = (byte_sel_i == 2'b10 & addr[0]) | (byte_sel_i == 2'b11 & |addr[1:0]);
    idle      = state_q == IDLE;
    busy      = state_q == BUSY;
    go        = idle & req & ~mis;
    ack       = busy & bus_ack_i;
    tmo       = busy & ~bus_ack_i & (cnt_q == CW'(TIMEOUT - 1));
    stall_o   = go | (busy & ~bus_ack_i & ~tmo);
    fmt_wdata = byte_sel_i == 2'b01 ? {4{mem_wdata_i[7:0]}} :
                byte_sel_i == 2'b10 ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
    fmt_wstrb = ~mem_we_i ? 4'b0000 :
                byte_sel_i == 2'b01 ? 4'b0001 << addr[1:0] :
                byte_sel_i == 2'b10 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    state_d   = go ? BUSY : (ack | tmo) ? IDLE : state_q;
    cnt_d     = (busy & ~bus_ack_i & ~tmo) ? cnt_q + CW'(1) : '0;
    addr_d    = go ? addr : addr_q;
    we_d      = go ? mem_we_i : we_q;
    bs_d      = go ? byte_sel_i : bs_q;
    uns_d     = go ? un_sign_i : uns_q;
    rd_d      = go ? rd_waddr_i : rd_q;
    wdata_d   = go ? fmt_wdata : wdata_q;
    wstrb_d   = go ? fmt_wstrb : wstrb_q;
    lane8     = addr_q[1:0] == 2'd0 ? bus_rdata_i[7:0] :
                addr_q[1:0] == 2'd1 ? bus_rdata_i[15:8] :
                addr_q[1:0] == 2'd2 ? bus_rdata_i[23:16] : bus_rdata_i[31:24];
    lane16    = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    ext       = bs_q == 2'b01 ? {{24{~uns_q & lane8[7]}}, lane8} :
                bs_q == 2'b10 ? {{16{~uns_q & lane16[15]}}, lane16} : bus_rdata_i;
    lv_d      = ack & ~bus_err_i & ~we_q;
    lwaddr_d  = lv_d ? rd_q : lwaddr_q;
    lwdata_d  = lv_d ? ext : lwdata_q;
    mis_d     = idle & req & mis;
    berr_d    = (ack & bus_err_i) | tmo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      bs_q     <= '0;
      uns_q    <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      lv_q     <= 1'b0;
      lwaddr_q <= '0;
      lwdata_q <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      bs_q     <= bs_d;
      uns_q    <= uns_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      lv_q     <= lv_d;
      lwaddr_q <= lwaddr_d;
      lwdata_q <= lwdata_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  assign bus_req_o    = state_q == BUSY;
  assign bus_we_o     = we_q;
  assign bus_addr_o   = {addr_q[31:2], 2'b00};
  assign bus_wdata_o  = wdata_q;
  assign bus_wstrb_o  = wstrb_q;
  assign load_valid_o = lv_q;
  assign load_waddr_o = lwaddr_q;
  assign load_wdata_o = lwdata_q;
  assign misalign_o   = mis_q;
  assign bus_err_o    = berr_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the execute/control stage. Accepts the combinational load/store request produced by execute (enable, address, store data, byte select, signedness) and runs a req/ack transaction on the data bus. Stalls the pipeline until the bus answers, then returns aligned, sign/zero-extended load data to the register file write port. Misaligned accesses and bus errors/timeouts are reported as one-cycle pulses.

## Interface
- TIMEOUT, 16, cycles `bus_req_o` may stay high without `bus_ack_i` before the access is aborted (≥1)
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- mem_re_i  input  1  load request from execute
- mem_raddr_i  input  32  load byte address
- mem_we_i  input  1  store request from execute
- mem_waddr_i  input  32  store byte address
- mem_wdata_i  input  32  store data (low-aligned)
- byte_sel_i  input  2  00 none, 01 byte, 10 halfword, 11 word
- un_sign_i  input  1  0 signed, 1 unsigned (loads only)
- rd_waddr_i  input  5  load destination register
- bus_req_o  output  1  bus request, held until ack
- bus_we_o  output  1  1 store, 0 load
- bus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata_o  output  32  lane-replicated store data
- bus_wstrb_o  output  4  byte write strobes (0000 on loads)
- bus_ack_i  input  1  transaction complete (sampled only while bus_req_o=1)
- bus_err_i  input  1  error qualifier, valid with bus_ack_i
- bus_rdata_i  input  32  read word, valid with bus_ack_i
- stall_o  output  1  hold PC and execute inputs
- load_valid_o  output  1  one-cycle register-file write strobe
- load_waddr_o  output  5  load destination
- load_wdata_o  output  32  extended load data
- misalign_o  output  1  one-cycle misaligned-access pulse
- bus_err_o  output  1  one-cycle bus error/timeout pulse

## Operation
- FSM states: IDLE, BUSY.
- Request valid in IDLE: (mem_we_i | mem_re_i) & byte_sel_i≠00. If both enables are high, the store wins. Effective address is mem_waddr_i for stores and mem_raddr_i for loads.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00. A misaligned request issues no bus request and does not stall. misalign_o pulses in the next cycle.
- Aligned request in IDLE: latch addr, we, byte_sel, un_sign, rd, and formatted data/strobes, then go to BUSY.
- Store formatting:
  - byte: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]
  - halfword: wdata={2{d[15:0]}}, wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1)
  - word: wdata=d, wstrb=1111
- BUSY: bus_req_o=1 with all bus outputs stable. A wait counter increments each cycle without ack.
- On bus_ack_i:
  - Return to IDLE.
  - If bus_err_i=0 and the access is a load, register the result.
  - If bus_err_i=1, pulse bus_err_o and suppress load_valid_o.
- Timeout: when the counter reaches TIMEOUT-1 without ack, drop bus_req_o, return to IDLE, and pulse bus_err_o. No load_valid_o.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (halfword). Sign-extend if un_sign=0, zero-extend if un_sign=1.
- rd=0 loads still access the bus and assert load_valid_o with load_waddr_o=0.
- stall_o = (IDLE & aligned request) | (BUSY & ~bus_ack_i & ~timeout).

## Timing
- Reset (async, immediate): state IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_wstrb_o=0, load_valid_o=0, load_waddr_o=0, load_wdata_o=0, misalign_o=0, bus_err_o=0, counter 0. Reset during BUSY abandons the transaction with no pulses.
- Cycle N: request seen in IDLE; stall_o=1 combinationally.
- Cycle N+1: BUSY, bus_req_o=1. Ack in cycle N+k (k≥1) sets stall_o=0 in that same cycle; execute advances at the following edge.
- load_valid_o, load_waddr_o and load_wdata_o are valid for exactly cycle N+k+1. Outputs hold their last value otherwise; only the strobe deasserts.
- Minimum load/store latency: 2 cycles in execute (zero-wait bus).
- misalign_o and bus_err_o are registered one-cycle pulses.
- A new request may be accepted in cycle N+k+1.
- bus_ack_i arriving while bus_req_o=0 is ignored.

## Test plan
- Word load, addr 0x100, ack in the first BUSY cycle, rdata 0xDEADBEEF → stall_o high for 1 cycle; load_valid_o at N+2 with wdata 0xDEADBEEF.
- Byte load, addr 0x103, rdata 0x80FF_0000:
  - un_sign=0 → wdata 0xFFFFFF80.
  - un_sign=1 → wdata 0x00000080.
  - Halfword load, addr 0x102, signed → 0xFFFF80FF.
- Byte store 0xA5 to addr 0x201 → bus_addr_o 0x200, wstrb 0010, wdata 0xA5A5A5A5, bus_we_o=1, no load_valid_o.
- Word load to addr 0x102 → no bus_req_o, stall_o=0, misalign_o pulse next cycle.
- Ack held off 3 cycles → stall_o high 4 cycles, bus outputs stable. With TIMEOUT=4 and no ack → bus_req_o drops after 4 cycles, bus_err_o pulse, no load_valid_o.
- Assert rst mid-BUSY → bus_req_o=0 immediately; after release, an idle cycle shows all outputs at their reset values.
